// File: rtl/io_pkg.sv
// io_pkg: shared defaults and handshake FSM state types for io_fifo_unit.
package io_pkg;
    localparam int IO_DATA_W_DEF = 16;
    localparam int IO_DEPTH_DEF  = 8;
    typedef enum logic {IN_IDLE, IN_ACK} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_ACK} out_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count.
// Ports: clk, rst (async, active-high); push/push_data write side; pop/pop_data
// read side (pop_data is the head word); full, empty, count status.
module sync_fifo import io_pkg::*; #(
    parameter int DATA_W = IO_DATA_W_DEF,
    parameter int DEPTH  = IO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_push, do_pop;
    // Gating uses only the registered status, so a same-cycle pop never
    // frees room for a push into a full FIFO and vice versa.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/io_fifo_unit.sv
// io_fifo_unit: buffered CPU input/output unit with RX/TX FIFOs and input timeout.
// Ports: clk, rst_b (async, active-high); CPU input handshake inp_req/inp_ack/inp_data;
// CPU output handshake out_req/out_data/out_ack; rx_valid/rx_data/rx_ready stream in;
// tx_valid/tx_data/tx_ready stream out; rx_count/tx_count occupancy; rx_timeout sticky flag.
module io_fifo_unit import io_pkg::*; #(
    parameter int                DATA_W      = IO_DATA_W_DEF,
    parameter int                DEPTH       = IO_DEPTH_DEF,
    parameter int                TIMEOUT     = 0,
    parameter logic [DATA_W-1:0] TIMEOUT_VAL = '1
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   inp_req,
    output logic                   inp_ack,
    output logic [DATA_W-1:0]      inp_data,
    input  logic                   out_req,
    input  logic [DATA_W-1:0]      out_data,
    output logic                   out_ack,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    output logic                   rx_ready,
    output logic                   tx_valid,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] rx_count,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic                   rx_timeout
);
    // Timer only has to reach TIMEOUT-1; TIMEOUT of 0 keeps a 1-bit dummy.
    localparam int            TW    = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    in_state_t         in_state, in_next;
    out_state_t        out_state, out_next;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] rx_head;
    logic              rx_full, rx_empty, rx_pop, to_fire;
    logic              tx_full, tx_empty, tx_push;
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst_b),
        .push(rx_valid), .push_data(rx_data),
        .pop(rx_pop), .pop_data(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst_b),
        .push(tx_push), .push_data(out_data),
        .pop(tx_ready), .pop_data(tx_data),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    always_comb begin
        rx_pop   = in_state == IN_IDLE && inp_req && !rx_empty;
        to_fire  = TIMEOUT != 0 && in_state == IN_IDLE && inp_req && rx_empty && timer == TLAST;
        in_next  = (rx_pop || to_fire) ? IN_ACK : (in_state == IN_ACK && !inp_req) ? IN_IDLE : in_state;
        inp_ack  = in_state == IN_ACK;
        tx_push  = out_state == OUT_IDLE && out_req && !tx_full;
        out_next = tx_push ? OUT_ACK : (out_state == OUT_ACK && !out_req) ? OUT_IDLE : out_state;
        out_ack  = out_state == OUT_ACK;
    end
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
        end
    end
    // Wait timer runs only while a request is stalled on an empty RX FIFO.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) timer <= '0;
        else if (!inp_req || in_state != IN_IDLE || rx_pop || to_fire) timer <= '0;
        else if (timer != '1) timer <= timer + TW'(1);
    end
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            inp_data   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            inp_data   <= rx_pop ? rx_head : to_fire ? TIMEOUT_VAL : inp_data;
            rx_timeout <= rx_timeout || to_fire;
        end
    end
endmodule

// File: tb/tb_io_fifo_unit.sv
// tb_io_fifo_unit: scoreboard-driven self-checking bench for io_fifo_unit.
module tb_io_fifo_unit;
    logic        clk = 0;
    logic        rst_b = 1;
    logic        inp_req = 0, out_req = 0, rx_valid = 0, tx_ready = 0;
    logic [15:0] out_data = 0, rx_data = 0;
    logic        inp_ack, out_ack, rx_ready, tx_valid, rx_timeout;
    logic [15:0] inp_data, tx_data;
    logic [3:0]  rx_count, tx_count;
    logic [15:0] rx_exp[$];
    logic [15:0] tx_exp[$];
    int checks = 0;
    int fails = 0;

    io_fifo_unit #(.DATA_W(16), .DEPTH(8), .TIMEOUT(5), .TIMEOUT_VAL(16'hFFFF)) dut (
        .clk(clk), .rst_b(rst_b),
        .inp_req(inp_req), .inp_ack(inp_ack), .inp_data(inp_data),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_count(rx_count), .tx_count(tx_count), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_push(input logic [15:0] w);
        rx_valid = 1;
        rx_data  = w;
        step();
        rx_valid = 0;
        rx_exp.push_back(w);
    endtask

    task automatic cpu_read(input int exp_lat, input bit is_to, input string name);
        int n;
        logic [15:0] e;
        inp_req = 1;
        n = 0;
        do begin step(); n++; end while (!inp_ack && n < 20);
        e = is_to ? 16'hFFFF : (rx_exp.size() > 0 ? rx_exp.pop_front() : 16'hxxxx);
        checks++; if (n !== exp_lat) begin fails++; $display("FAIL %s ack_latency: got %0d expected %0d", name, n, exp_lat); end
        checks++; if (inp_data !== e) begin fails++; $display("FAIL %s inp_data: got %h expected %h", name, inp_data, e); end
        inp_req = 0;
        step();
        checks++; if (inp_ack !== 1'b0) begin fails++; $display("FAIL %s ack_fall: got %b expected 0", name, inp_ack); end
    endtask

    task automatic cpu_write(input logic [15:0] w, input string name);
        int n;
        out_req  = 1;
        out_data = w;
        n = 0;
        do begin step(); n++; end while (!out_ack && n < 20);
        checks++; if (n !== 1) begin fails++; $display("FAIL %s out_ack_latency: got %0d expected 1", name, n); end
        tx_exp.push_back(w);
        out_req = 0;
        step();
        checks++; if (out_ack !== 1'b0) begin fails++; $display("FAIL %s out_ack_fall: got %b expected 0", name, out_ack); end
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (inp_ack !== 1'b0) begin fails++; $display("FAIL reset inp_ack: got %b expected 0", inp_ack); end
        checks++; if (out_ack !== 1'b0) begin fails++; $display("FAIL reset out_ack: got %b expected 0", out_ack); end
        checks++; if (inp_data !== 16'h0) begin fails++; $display("FAIL reset inp_data: got %h expected 0000", inp_data); end
        checks++; if (rx_timeout !== 1'b0) begin fails++; $display("FAIL reset rx_timeout: got %b expected 0", rx_timeout); end
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset tx_valid: got %b expected 0", tx_valid); end
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL reset rx_count: got %0d expected 0", rx_count); end
        checks++; if (tx_count !== 4'd0) begin fails++; $display("FAIL reset tx_count: got %0d expected 0", tx_count); end
        checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL reset rx_ready: got %b expected 1", rx_ready); end
        rst_b = 0;
        step();
        checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL post_reset rx_ready: got %b expected 1", rx_ready); end
    endtask

    task automatic test_input();
        rx_push(16'h1234);
        rx_push(16'hBEEF);
        checks++; if (rx_count !== 4'd2) begin fails++; $display("FAIL input rx_count: got %0d expected 2", rx_count); end
        cpu_read(1, 0, "input_first");
        checks++; if (rx_count !== 4'd1) begin fails++; $display("FAIL input rx_count: got %0d expected 1", rx_count); end
        cpu_read(1, 0, "input_second");
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL input rx_count: got %0d expected 0", rx_count); end
    endtask

    task automatic test_tx_fill();
        tx_ready = 0;
        for (int i = 0; i < 8; i++) cpu_write(16'hA000 + 16'(i), "tx_fill");
        checks++; if (tx_count !== 4'd8) begin fails++; $display("FAIL tx_fill tx_count: got %0d expected 8", tx_count); end
        checks++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL tx_fill tx_valid: got %b expected 1", tx_valid); end
        out_req  = 1;
        out_data = 16'hA008;
        step(); step(); step();
        checks++; if (out_ack !== 1'b0) begin fails++; $display("FAIL tx_full_stall out_ack: got %b expected 0", out_ack); end
        checks++; if (tx_data !== tx_exp[0]) begin fails++; $display("FAIL tx_head tx_data: got %h expected %h", tx_data, tx_exp[0]); end
        void'(tx_exp.pop_front());
        tx_ready = 1;
        step();
        tx_ready = 0;
        checks++; if (tx_count !== 4'd7) begin fails++; $display("FAIL tx_pop tx_count: got %0d expected 7", tx_count); end
        checks++; if (out_ack !== 1'b0) begin fails++; $display("FAIL tx_pop_same_cycle out_ack: got %b expected 0", out_ack); end
        step();
        checks++; if (out_ack !== 1'b1) begin fails++; $display("FAIL tx_ninth out_ack: got %b expected 1", out_ack); end
        checks++; if (tx_count !== 4'd8) begin fails++; $display("FAIL tx_ninth tx_count: got %0d expected 8", tx_count); end
        tx_exp.push_back(16'hA008);
        out_req = 0;
        step();
        tx_ready = 1;
        while (tx_exp.size() > 0) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== tx_exp[0]) begin fails++; $display("FAIL tx_drain tx_valid/tx_data: got %b/%h expected 1/%h", tx_valid, tx_data, tx_exp[0]); end
            void'(tx_exp.pop_front());
            step();
        end
        tx_ready = 0;
        checks++; if (tx_valid !== 1'b0 || tx_count !== 4'd0) begin fails++; $display("FAIL tx_empty tx_valid/tx_count: got %b/%0d expected 0/0", tx_valid, tx_count); end
    endtask

    task automatic test_rx_full();
        for (int i = 0; i < 8; i++) rx_push(16'hC000 + 16'(i));
        checks++; if (rx_count !== 4'd8) begin fails++; $display("FAIL rx_full rx_count: got %0d expected 8", rx_count); end
        checks++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_full rx_ready: got %b expected 0", rx_ready); end
        inp_req  = 1;
        rx_valid = 1;
        rx_data  = 16'hDEAD;
        step();
        rx_valid = 0;
        checks++; if (rx_count !== 4'd7) begin fails++; $display("FAIL rx_full_popush rx_count: got %0d expected 7", rx_count); end
        checks++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_full_popush rx_ready: got %b expected 1", rx_ready); end
        checks++; if (inp_ack !== 1'b1 || inp_data !== rx_exp[0]) begin fails++; $display("FAIL rx_full_popush ack/data: got %b/%h expected 1/%h", inp_ack, inp_data, rx_exp[0]); end
        void'(rx_exp.pop_front());
        inp_req = 0;
        step();
        while (rx_exp.size() > 0) cpu_read(1, 0, "rx_drain");
        checks++; if (rx_count !== 4'd0) begin fails++; $display("FAIL rx_drain rx_count: got %0d expected 0", rx_count); end
    endtask

    task automatic test_timeout();
        cpu_read(5, 1, "timeout");
        checks++; if (rx_timeout !== 1'b1) begin fails++; $display("FAIL timeout rx_timeout: got %b expected 1", rx_timeout); end
        rx_push(16'h5A5A);
        cpu_read(1, 0, "after_timeout");
        checks++; if (rx_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky rx_timeout: got %b expected 1", rx_timeout); end
    endtask

    task automatic test_long_req();
        logic [15:0] e;
        rx_push(16'h1111);
        rx_push(16'h2222);
        rx_push(16'h3333);
        inp_req = 1;
        step();
        e = rx_exp.pop_front();
        checks++; if (inp_ack !== 1'b1 || inp_data !== e) begin fails++; $display("FAIL long_req first ack/data: got %b/%h expected 1/%h", inp_ack, inp_data, e); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rx_count !== 4'd2 || inp_ack !== 1'b1 || inp_data !== e) begin fails++; $display("FAIL long_req hold count/ack/data: got %0d/%b/%h expected 2/1/%h", rx_count, inp_ack, inp_data, e); end
        end
        inp_req = 0;
        step();
        checks++; if (inp_ack !== 1'b0) begin fails++; $display("FAIL long_req ack_fall: got %b expected 0", inp_ack); end
        cpu_read(1, 0, "long_req_second");
        checks++; if (rx_count !== 4'd1) begin fails++; $display("FAIL long_req rx_count: got %0d expected 1", rx_count); end
        cpu_read(1, 0, "long_req_third");
    endtask

    task automatic test_reset_mid();
        cpu_write(16'h7777, "reset_mid_tx");
        rx_push(16'h4444);
        rx_push(16'h5555);
        rx_push(16'h6666);
        inp_req = 1;
        step();
        checks++; if (inp_ack !== 1'b1) begin fails++; $display("FAIL reset_mid pre inp_ack: got %b expected 1", inp_ack); end
        rst_b = 1;
        step();
        checks++; if (inp_ack !== 1'b0) begin fails++; $display("FAIL reset_mid inp_ack: got %b expected 0", inp_ack); end
        checks++; if (rx_count !== 4'd0 || tx_count !== 4'd0) begin fails++; $display("FAIL reset_mid counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
        checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_mid tx_valid: got %b expected 0", tx_valid); end
        checks++; if (inp_data !== 16'h0 || rx_timeout !== 1'b0) begin fails++; $display("FAIL reset_mid inp_data/rx_timeout: got %h/%b expected 0000/0", inp_data, rx_timeout); end
        rx_exp.delete();
        tx_exp.delete();
        inp_req = 0;
        rst_b = 0;
        step();
        checks++; if (rx_ready !== 1'b1 || inp_ack !== 1'b0) begin fails++; $display("FAIL reset_mid release rx_ready/inp_ack: got %b/%b expected 1/0", rx_ready, inp_ack); end
    endtask

    initial begin
        test_reset();
        test_input();
        test_tx_fill();
        test_rx_full();
        test_timeout();
        test_long_req();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/io_fifo_unit.md
# io_fifo_unit

Parametrised, buffered successor to the single-word input and output units attached to the CPU's `inp_*`/`out_*` ports. It pairs an RX FIFO and a TX FIFO with the CPU four-phase req/ack handshake on one side and ready/valid streams to external devices on the other. A programmable timeout releases a CPU input request that would otherwise block forever on an empty RX FIFO.

## Interface
Parameters:
- `DATA_W`, 16: word width on every data port.
- `DEPTH`, 8: entries per FIFO; must be a power of two, at least 2.
- `TIMEOUT`, 0: cycles an input request may wait on an empty RX FIFO. 0 disables the timeout.
- `TIMEOUT_VAL`, all ones: word returned to the CPU when a timeout fires.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_b` in 1: reset.
  - One clock; reset is asynchronous and active-high.
  - Port name kept for SoC port compatibility; it is asserted high.
- `inp_req` in 1: CPU requests one input word.
- `inp_ack` out 1: input word valid on `inp_data`; held until `inp_req` falls.
- `inp_data` out DATA_W: registered input word.
- `out_req` in 1: CPU offers one word on `out_data`.
- `out_data` in DATA_W: CPU output word.
- `out_ack` out 1: word accepted; held until `out_req` falls.
- `rx_valid` in 1: external source presents `rx_data`.
- `rx_data` in DATA_W: external input word.
- `rx_ready` out 1: RX FIFO can accept a word (`!rx_full`).
- `tx_valid` out 1: TX FIFO non-empty; `tx_data` is valid.
- `tx_data` out DATA_W: TX FIFO head word (show-ahead).
- `tx_ready` in 1: external sink accepts `tx_data`.
- `rx_count` out $clog2(DEPTH)+1: RX occupancy.
- `tx_count` out $clog2(DEPTH)+1: TX occupancy.
- `rx_timeout` out 1: sticky; set when a timeout fires, cleared only by reset.

## Operation
- **RX push:** on `rx_valid & rx_ready`.
- **TX pop:** on `tx_valid & tx_ready`.
- **Input FSM** (states `IN_IDLE`, `IN_ACK`):
  - `IN_IDLE`, `inp_req=1`, RX non-empty: pop the RX head into `inp_data`, go to `IN_ACK`, clear the wait timer.
  - `IN_IDLE`, `inp_req=1`, RX empty, `TIMEOUT!=0`, wait timer equals `TIMEOUT-1`: load `TIMEOUT_VAL` into `inp_data`, set `rx_timeout`, go to `IN_ACK`.
  - `IN_IDLE`, `inp_req=1`, RX empty, timeout not reached: increment the wait timer. The timer saturates and clears whenever `inp_req=0`.
  - `IN_ACK`: `inp_ack=1`. Stay while `inp_req=1`; go to `IN_IDLE` when `inp_req=0`. At most one word is delivered per request.
- **Output FSM** (states `OUT_IDLE`, `OUT_ACK`):
  - `OUT_IDLE`, `out_req=1`, TX not full: push `out_data`, go to `OUT_ACK`.
  - `OUT_IDLE`, `out_req=1`, TX full: wait in `OUT_IDLE`. There is no timeout on this side.
  - `OUT_ACK`: `out_ack=1`; go to `OUT_IDLE` when `out_req=0`.
- **FIFO arithmetic:**
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
  - Count is one bit wider; full when `count==DEPTH`, empty when `count==0`.
  - A simultaneous push and pop leaves the count unchanged.
  - A push is never accepted while full, even when a pop happens in the same cycle.
  - A pop is never performed while empty, even when a push happens in the same cycle.
- **Reset values:**
  - Outputs: `inp_ack=0`, `out_ack=0`, `inp_data=0`, `rx_timeout=0`, `tx_valid=0`, both counts 0, `rx_ready=1`.
  - Internal: both FSMs idle, pointers 0.
  - Reset mid-handshake or mid-transfer discards all FIFO contents and the word in flight.

## Timing
- `inp_req`/`out_req` are sampled at the rising edge. `inp_ack`/`out_ack` are registered and rise 1 cycle after req is sampled high, provided the FIFO condition holds.
- `inp_data` is stable for the whole time `inp_ack=1`.
- `out_data` must be stable from `out_req` rising until `out_ack` is seen.
- Ack falls 1 cycle after req is sampled low. A new request is recognised no earlier than the following cycle.
- RX latency: a word pushed at edge N can be popped by an input request sampled at edge N+1 or later.
- TX latency: a word pushed at edge N has `tx_valid=1` after edge N; `tx_data` is the head word combinationally from the FIFO storage.
- Timeout: the ack rises exactly `TIMEOUT` edges after the first edge at which `inp_req=1` is sampled with RX empty.

## Structure
- Package `io_pkg`: `IO_DATA_W_DEF`, `IO_DEPTH_DEF`, and state typedefs `in_state_t` / `out_state_t`.
- Sub-module `sync_fifo`, parameterised by `DATA_W` and `DEPTH`, with push/pop/full/empty/count ports. It is instantiated twice (RX and TX); the handshake FSMs and timeout counter live in `io_fifo_unit`.

## Test plan
- **Reset, then input:** push 0x1234 and 0xBEEF via rx.
  - CPU input handshake twice → `inp_data` 0x1234 then 0xBEEF.
  - `inp_ack` high 1 cycle after each req.
  - `rx_count` goes 2→1→0.
- **TX fill:** CPU writes 8 words with `tx_ready=0` and `DEPTH=8`.
  - 9th `out_req` gets no ack; `tx_count=8`.
  - Assert `tx_ready` for 1 cycle → 9th write acked on the next cycle, order preserved on `tx_data`.
- **RX full:** 8 rx pushes → `rx_ready=0`.
  - Same-cycle CPU pop plus an `rx_valid` word → pop occurs, push rejected, `rx_count=7`, `rx_ready=1` the next cycle.
- **Timeout:** `TIMEOUT=5`, RX empty, hold `inp_req` → `inp_ack` rises on the 5th edge with `inp_data=16'hFFFF`, `rx_timeout=1`.
  - A later rx word is delivered normally; `rx_timeout` remains 1.
- **Long request:** `inp_req` held high for 4 cycles with RX count 3 → exactly one pop (count 2).
  - After req falls and rises again → second pop.
- **Reset mid-operation:** assert `rst_b` during `IN_ACK` with 3 words queued → next cycle `inp_ack=0`, counts 0, `tx_valid=0`.
